cmp_rs: RTL
===========

# cmp_rs

Reservation station for the branch/compare functional unit in the out-of-order core. Accepts dispatched compare micro-ops from the rename/dispatch stage and holds them until both operands are known. Captures missing operands from CDB broadcasts. Presents every slot in parallel, with a per-slot ready mask, to the combinational compare array directly downstream; each slot is freed on the cycle it is presented ready.

## Interface
- SIZE, 8: number of slots; must match the downstream compare array width
- TAG_W, 4: ROB tag width
- CDB_W, 2: number of CDB broadcast ports
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush (mispredict); clears all slots
- disp_valid  in  1  dispatch request this cycle
- disp_op  in  3  compare opcode (funct3 branch encoding: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu); stored and passed through unchanged
- disp_tag  in  TAG_W  destination ROB tag
- disp_r1_rdy / disp_r2_rdy  in  1 each  operand value already known
- disp_r1_val / disp_r2_val  in  32 each  operand value (valid when matching rdy=1)
- disp_r1_tag / disp_r2_tag  in  TAG_W each  producer tag (used when matching rdy=0)
- cdb_valid  in  CDB_W  per-port broadcast valid
- cdb_tag  in  CDB_W x TAG_W  per-port producer tag
- cdb_data  in  CDB_W x 32  per-port result
- full  out  1  all SIZE slots occupied
- empty  out  1  no slot occupied
- count  out  $clog2(SIZE)+1  occupied slot count
- issue_ready  out  SIZE  slot i valid with both operands captured
- issue_op  out  SIZE x 3  per-slot opcode
- issue_tag  out  SIZE x TAG_W  per-slot ROB tag
- issue_r1 / issue_r2  out  SIZE x 32 each  per-slot operand values

## Operation
- Per-slot state: valid, op, tag, r1 {rdy, val, tag}, r2 {rdy, val, tag}.
- Dispatch: when disp_valid=1 and full=0, write the lowest-index slot with valid=0, as seen at the start of the cycle. Slots freed by issue in the same cycle are not reusable until the next cycle. When full=1, dispatch is ignored with no state change; upstream must stall on full.
- Dispatch bypass: when an incoming operand has rdy=0 and a same-cycle CDB port matches its tag, the slot stores the CDB data with rdy=1.
- Wakeup: every cycle, each CDB port with cdb_valid=1 is compared against every valid slot operand with rdy=0. On a tag match, the operand latches cdb_data and sets rdy=1. Operands already holding rdy=1 are never overwritten. Duplicate tags across CDB ports in one cycle are illegal; if they occur, the lowest port index wins.
- Issue:
  - issue_ready[i] = valid[i] & r1.rdy[i] & r2.rdy[i], decoded combinationally from registered state only.
  - A slot with issue_ready[i]=1 clears valid[i] at the next edge, so each op is presented ready for exactly one cycle.
  - Multiple slots may issue in the same cycle. Downstream always accepts; there is no back-pressure.
- Invalid slots drive issue_op, issue_tag, issue_r1 and issue_r2 as 0.
- full, empty and count are combinational from the valid bits.
- Flush: valid cleared in all slots at the next edge. Flush has priority over same-cycle dispatch and wakeup. Other slot fields are don't-care.
- Reset: identical effect to flush, plus all stored fields cleared to 0.

## Timing
- Reset values: issue_ready=0, all issue_* = 0, full=0, empty=1, count=0.
- Both operands ready at dispatch (edge t): issue_ready asserts in cycle t+1; slot freed at edge t+2.
- Operand woken by CDB at edge t: issue_ready asserts in cycle t+1, provided the other operand is ready.
- Occupancy: count changes at most by +1 (dispatch) and -k (k slots issuing) per edge, both applied in the same cycle.
- Full boundary: with SIZE occupied and one slot issuing, full stays 1 during that cycle. Dispatch is accepted the following cycle.
- Reset or flush mid-operation: all pending ops are discarded. No issue_ready is asserted in the cycle after the rst/flush edge.

## Test plan
- Reset: assert rst 2 cycles -> full=0, empty=1, count=0, issue_ready=8'h00.
- Ready dispatch: dispatch op=000, tag=3, r1=r2=5 (both rdy) at edge t -> cycle t+1 slot0 issue_ready=8'h01, issue_tag[0]=3, issue_r1[0]=5; cycle t+2 issue_ready=0, empty=1.
- Wakeup and bypass:
  - Dispatch tag=4, r1 waiting on tag 7, r2 rdy=9 -> issue_ready=0.
  - CDB port1 broadcasts tag 7 data 32'hFFFF_FFFF -> next cycle slot0 ready with issue_r1[0]=32'hFFFF_FFFF.
  - Repeat with the broadcast in the dispatch cycle -> ready in cycle t+1.
- Fill/full: 8 back-to-back dispatches, all operands waiting -> count=8, full=1.
  - A 9th dispatch is dropped, count stays 8.
  - Wake slot 5 -> slot 5 issues.
  - Next dispatch lands in slot 5.
- Multi-issue: 3 slots waiting on tags 2, 2 and 6; CDB port0 tag 2 and port1 tag 6 in the same cycle -> next cycle issue_ready has all 3 bits set, and count drops by 3 the following edge.
- Flush: 4 occupied slots plus a same-cycle dispatch with flush=1 -> next cycle empty=1, count=0, issue_ready=0.

Source files
------------

// File: rtl/cmp_rs.sv
// Reservation station for the branch/compare unit: holds dispatched compare ops until
// both operands are known, wakes operands from the CDB, and presents all slots in parallel.
module cmp_rs #(
  parameter int SIZE  = 8,
  parameter int TAG_W = 4,
  parameter int CDB_W = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              disp_valid,
  input  logic [2:0]                        disp_op,
  input  logic [TAG_W-1:0]                  disp_tag,
  input  logic                              disp_r1_rdy,
  input  logic [31:0]                       disp_r1_val,
  input  logic [TAG_W-1:0]                  disp_r1_tag,
  input  logic                              disp_r2_rdy,
  input  logic [31:0]                       disp_r2_val,
  input  logic [TAG_W-1:0]                  disp_r2_tag,
  input  logic [CDB_W-1:0]                  cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]       cdb_tag,
  input  logic [CDB_W-1:0][31:0]            cdb_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(SIZE):0]             count,
  output logic [SIZE-1:0]                   issue_ready,
  output logic [SIZE-1:0][2:0]              issue_op,
  output logic [SIZE-1:0][TAG_W-1:0]        issue_tag,
  output logic [SIZE-1:0][31:0]             issue_r1,
  output logic [SIZE-1:0][31:0]             issue_r2
);

  localparam int CNT_W = $clog2(SIZE) + 1;

  logic [SIZE-1:0]             valid_q;
  logic [SIZE-1:0][2:0]        op_q;
  logic [SIZE-1:0][TAG_W-1:0]  tag_q;
  logic [SIZE-1:0]             r1_rdy_q, r2_rdy_q;
  logic [SIZE-1:0][31:0]       r1_val_q, r2_val_q;
  logic [SIZE-1:0][TAG_W-1:0]  r1_tag_q, r2_tag_q;

  logic [SIZE-1:0]             r1_wake, r2_wake;
  logic [SIZE-1:0][31:0]       r1_wdata, r2_wdata;
  logic                        d1_hit, d2_hit;
  logic [31:0]                 d1_data, d2_data;
  logic [SIZE-1:0]             disp_sel;
  logic                        disp_found;
  logic                        disp_go;
  logic [CNT_W-1:0]            count_c;

  // Scan from the highest port down so the lowest matching port wins on duplicate tags.
  function automatic logic [32:0] cdb_lookup(
    input logic [TAG_W-1:0]            t,
    input logic [CDB_W-1:0]            v,
    input logic [CDB_W-1:0][TAG_W-1:0] tags,
    input logic [CDB_W-1:0][31:0]      data
  );
    logic [32:0] res;
    res = '0;
    for (int p = CDB_W - 1; p >= 0; p--) begin
      if (v[p] && tags[p] == t) res = {1'b1, data[p]};
    end
    return res;
  endfunction

  always_comb begin
    r1_wake  = '0;
    r2_wake  = '0;
    r1_wdata = '0;
    r2_wdata = '0;
    for (int i = 0; i < SIZE; i++) begin
      {r1_wake[i], r1_wdata[i]} = cdb_lookup(r1_tag_q[i], cdb_valid, cdb_tag, cdb_data);
      {r2_wake[i], r2_wdata[i]} = cdb_lookup(r2_tag_q[i], cdb_valid, cdb_tag, cdb_data);
    end
    {d1_hit, d1_data} = cdb_lookup(disp_r1_tag, cdb_valid, cdb_tag, cdb_data);
    {d2_hit, d2_data} = cdb_lookup(disp_r2_tag, cdb_valid, cdb_tag, cdb_data);
  end

  // Free-slot choice uses registered valid only, so slots issuing this cycle are not reused.
  always_comb begin
    disp_sel   = '0;
    disp_found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (!valid_q[i] && !disp_found) begin
        disp_sel[i] = 1'b1;
        disp_found  = 1'b1;
      end
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < SIZE; i++) count_c = count_c + CNT_W'(valid_q[i]);
  end

  assign count   = count_c;
  assign full    = (count_c == CNT_W'(SIZE));
  assign empty   = (valid_q == '0);
  assign disp_go = disp_valid & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      r1_rdy_q <= '0;
      r2_rdy_q <= '0;
      r1_val_q <= '0;
      r2_val_q <= '0;
      r1_tag_q <= '0;
      r2_tag_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (issue_ready[i]) valid_q[i] <= 1'b0;
        if (valid_q[i] && !r1_rdy_q[i] && r1_wake[i]) begin
          r1_rdy_q[i] <= 1'b1;
          r1_val_q[i] <= r1_wdata[i];
        end
        if (valid_q[i] && !r2_rdy_q[i] && r2_wake[i]) begin
          r2_rdy_q[i] <= 1'b1;
          r2_val_q[i] <= r2_wdata[i];
        end
        if (disp_go && disp_sel[i]) begin
          valid_q[i]  <= 1'b1;
          op_q[i]     <= disp_op;
          tag_q[i]    <= disp_tag;
          r1_rdy_q[i] <= disp_r1_rdy | d1_hit;
          r1_val_q[i] <= disp_r1_rdy ? disp_r1_val : d1_data;
          r1_tag_q[i] <= disp_r1_tag;
          r2_rdy_q[i] <= disp_r2_rdy | d2_hit;
          r2_val_q[i] <= disp_r2_rdy ? disp_r2_val : d2_data;
          r2_tag_q[i] <= disp_r2_tag;
        end
      end
    end
  end

  assign issue_ready = valid_q & r1_rdy_q & r2_rdy_q;

  // Stale fields survive a flush, so outputs are gated by valid.
  always_comb begin
    issue_op  = '0;
    issue_tag = '0;
    issue_r1  = '0;
    issue_r2  = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (valid_q[i]) begin
        issue_op[i]  = op_q[i];
        issue_tag[i] = tag_q[i];
        issue_r1[i]  = r1_val_q[i];
        issue_r2[i]  = r2_val_q[i];
      end
    end
  end

endmodule
